// File: rtl/i2c_cfg_target.sv
// I2C target with a byte-wide register file, fabric read taps and write strobes.
// Inputs are synchronised and glitch-filtered; bus decisions lag the pads by 2+FILTER_LEN clk.
module i2c_cfg_target #(
  parameter logic [6:0] I2C_ADDR   = 7'h39,
  parameter int         NUM_REGS   = 16,
  parameter int         FILTER_LEN = 3,
  localparam int        AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          scl_in,
  input  logic          sda_in,
  output logic          sda_oe,
  input  logic [AW-1:0] tap_addr,
  output logic [7:0]    tap_data,
  output logic          wr_stb,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_WDATA, S_RDATA, S_WAIT_STOP
  } state_t;

  // Index 0 carries SCL, index 1 carries SDA.
  logic [1:0]    s1_q, s2_q, filt_q, prev_q;
  logic [CW-1:0] fcnt_q [2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q   <= 2'b11;
      s2_q   <= 2'b11;
      filt_q <= 2'b11;
      prev_q <= 2'b11;
      for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
    end else begin
      s1_q   <= {sda_in, scl_in};
      s2_q   <= s1_q;
      prev_q <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == CW'(FILTER_LEN - 1)) begin
          filt_q[i] <= s2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + CW'(1);
        end
      end
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  =  filt_q[0] & ~prev_q[0];
  assign scl_fall  = ~filt_q[0] &  prev_q[0];
  assign start_det =  filt_q[0] &  prev_q[0] &  prev_q[1] & ~filt_q[1];
  assign stop_det  =  filt_q[0] &  prev_q[0] & ~prev_q[1] &  filt_q[1];

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [7:0]    sr_q;
  logic          rw_q, oe_q, busy_q, stb_q;
  logic [AW-1:0] ptr_q, waddr_q;
  logic [7:0]    wdata_q;
  logic [7:0]    regs_q [NUM_REGS];

  logic [7:0]    rx_byte;
  logic [AW-1:0] ptr_d;
  assign rx_byte = {sr_q[6:0], filt_q[1]};
  assign ptr_d   = ptr_q + AW'(1);

  // cnt_q: 0..7 data bits, 8 = ninth (ACK) clock pending, 9 = ACK clock in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      rw_q    <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      stb_q   <= 1'b0;
      ptr_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      stb_q <= 1'b0;
      if (stop_det) begin
        state_q <= S_IDLE;
        oe_q    <= 1'b0;
        busy_q  <= 1'b0;
        cnt_q   <= '0;
      end else if (start_det) begin
        state_q <= S_ADDR;
        oe_q    <= 1'b0;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          S_ADDR, S_ADDR_ACK, S_PTR, S_WDATA: begin
            if (scl_rise && cnt_q < 4'd8) begin
              sr_q  <= rx_byte;
              cnt_q <= cnt_q + 4'd1;
              if (cnt_q == 4'd7) begin
                if (state_q == S_ADDR) begin
                  if (rx_byte[7:1] == I2C_ADDR) begin
                    state_q <= S_ADDR_ACK;
                    busy_q  <= 1'b1;
                    rw_q    <= rx_byte[0];
                  end else begin
                    state_q <= S_WAIT_STOP;
                    busy_q  <= 1'b0;
                  end
                end else if (state_q == S_PTR) begin
                  ptr_q <= rx_byte[AW-1:0];
                end else if (state_q == S_WDATA) begin
                  regs_q[ptr_q] <= rx_byte;
                  stb_q         <= 1'b1;
                  waddr_q       <= ptr_q;
                  wdata_q       <= rx_byte;
                  ptr_q         <= ptr_d;
                end
              end
            end else if (scl_fall && cnt_q == 4'd8) begin
              oe_q  <= 1'b1;
              cnt_q <= 4'd9;
            end else if (scl_fall && cnt_q == 4'd9) begin
              cnt_q <= '0;
              if (state_q == S_ADDR_ACK && rw_q) begin
                state_q <= S_RDATA;
                sr_q    <= regs_q[ptr_q];
                oe_q    <= ~regs_q[ptr_q][7];
              end else begin
                oe_q    <= 1'b0;
                state_q <= (state_q == S_ADDR_ACK) ? S_PTR : S_WDATA;
              end
            end
          end
          S_RDATA: begin
            if (scl_rise) begin
              if (cnt_q < 4'd8) begin
                cnt_q <= cnt_q + 4'd1;
              end else if (cnt_q == 4'd8) begin
                if (!filt_q[1]) begin
                  ptr_q <= ptr_d;
                  sr_q  <= regs_q[ptr_d];
                  cnt_q <= 4'd9;
                end else begin
                  state_q <= S_WAIT_STOP;
                  busy_q  <= 1'b0;
                  oe_q    <= 1'b0;
                end
              end
            end else if (scl_fall) begin
              if (cnt_q >= 4'd1 && cnt_q <= 4'd7) begin
                sr_q <= {sr_q[6:0], 1'b0};
                oe_q <= ~sr_q[6];
              end else if (cnt_q == 4'd8) begin
                oe_q <= 1'b0;
              end else if (cnt_q == 4'd9) begin
                oe_q  <= ~sr_q[7];
                cnt_q <= '0;
              end
            end
          end
          S_IDLE, S_WAIT_STOP: ;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign sda_oe   = oe_q;
  assign busy     = busy_q;
  assign wr_stb   = stb_q;
  assign wr_addr  = waddr_q;
  assign wr_data  = wdata_q;
  assign tap_data = regs_q[tap_addr];

endmodule

// File: tb/tb_i2c_cfg_target.sv
// Bench for i2c_cfg_target: bit-level I2C master, register-file model and scoreboard.
`timescale 1ns/1ps
module tb_i2c_cfg_target;

  localparam int H = 12;
  localparam int Q = 6;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [3:0] tap_addr = '0;
  logic       sda_bus;
  logic       sda_oe, wr_stb, busy;
  logic [3:0] wr_addr;
  logic [7:0] wr_data, tap_data;

  assign sda_bus = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  i2c_cfg_target dut (
    .clk(clk), .reset_n(reset_n), .scl_in(scl_m), .sda_in(sda_bus),
    .sda_oe(sda_oe), .tap_addr(tap_addr), .tap_data(tap_data),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: register array plus a pointer that survives transactions.
  int mem [16];
  int ptr = 0;
  int exp_wr_q[$], exp_ack_q[$], act_ack_q[$], exp_rd_q[$], act_rd_q[$];
  int wdat [8];
  int wbit_cnt = 0;
  int glitch_at = -1;
  bit quiet = 0, oe_seen = 0, busy_seen = 0;
  logic oe_prev = 1'b0;

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (reset_n && wr_stb) begin
      if (exp_wr_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL wr_unexpected actual=%0d/0x%0h expected=none", wr_addr, wr_data);
      end else begin
        int e;
        e = exp_wr_q.pop_front();
        chk("wr_addr", int'(wr_addr), e >> 8);
        chk("wr_data", int'(wr_data), e & 255);
      end
    end
    while (act_ack_q.size() > 0) begin
      int a;
      a = act_ack_q.pop_front();
      if (exp_ack_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL ack_extra actual=%0d expected=none", a);
      end else chk("ack", a, exp_ack_q.pop_front());
    end
    while (act_rd_q.size() > 0) begin
      int d;
      d = act_rd_q.pop_front();
      if (exp_rd_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL rd_extra actual=0x%0h expected=none", d);
      end else chk("rd_data", d, exp_rd_q.pop_front());
    end
    if (reset_n && sda_oe != oe_prev) chk("oe_change_scl_low", int'(scl_m), 0);
    oe_prev = sda_oe;
    if (quiet && sda_oe) oe_seen = 1;
    if (quiet && busy) busy_seen = 1;
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wbit(input logic b);
    wbit_cnt++;
    wclk(Q); sda_m = b; wclk(Q); scl_m = 1'b1;
    if (wbit_cnt == glitch_at) begin
      wclk(4); scl_m = 1'b0; wclk(1); scl_m = 1'b1; wclk(H - 5);
    end else wclk(H);
    scl_m = 1'b0;
  endtask

  task automatic rbit(output logic b);
    wclk(Q); sda_m = 1'b1; wclk(Q); scl_m = 1'b1;
    wclk(Q); b = sda_bus; wclk(H - Q); scl_m = 1'b0;
  endtask

  task automatic start_c;
    wclk(Q); sda_m = 1'b1; wclk(Q); scl_m = 1'b1; wclk(H); sda_m = 1'b0; wclk(H); scl_m = 1'b0;
  endtask

  task automatic stop_c;
    wclk(Q); sda_m = 1'b0; wclk(Q); scl_m = 1'b1; wclk(H); sda_m = 1'b1; wclk(H);
  endtask

  task automatic wbyte(input logic [7:0] b, input int exp_ack);
    logic a;
    exp_ack_q.push_back(exp_ack);
    for (int i = 7; i >= 0; i--) wbit(b[i]);
    rbit(a);
    act_ack_q.push_back(int'(a));
  endtask

  task automatic rbyte(input logic nack);
    logic [7:0] d;
    for (int i = 7; i >= 0; i--) rbit(d[i]);
    wbit(nack);
    act_rd_q.push_back(int'(d));
  endtask

  // Write transaction: wdat[0] is the pointer byte, the rest are data.
  task automatic t_write(input logic [6:0] a, input int n);
    bit m;
    m = (a == 7'h39);
    if (!m) begin quiet = 1; oe_seen = 0; busy_seen = 0; end
    start_c;
    wbyte({a, 1'b0}, m ? 0 : 1);
    chk("busy_after_addr", int'(busy), m ? 1 : 0);
    for (int i = 0; i < n; i++) begin
      if (m) begin
        if (i == 0) ptr = wdat[0] % 16;
        else begin
          exp_wr_q.push_back((ptr << 8) | wdat[i]);
          mem[ptr] = wdat[i];
          ptr = (ptr + 1) % 16;
        end
      end
      wbyte(8'(wdat[i]), m ? 0 : 1);
    end
    stop_c;
    chk("busy_after_stop", int'(busy), 0);
    if (!m) begin
      quiet = 0;
      chk("mismatch_oe_quiet", int'(oe_seen), 0);
      chk("mismatch_busy_quiet", int'(busy_seen), 0);
    end
  endtask

  task automatic t_read(input bit set_ptr, input int p, input int n);
    start_c;
    if (set_ptr) begin
      wbyte({7'h39, 1'b0}, 0);
      ptr = p % 16;
      wbyte(8'(p), 0);
      start_c;
    end
    wbyte({7'h39, 1'b1}, 0);
    for (int i = 0; i < n; i++) begin
      exp_rd_q.push_back(mem[ptr]);
      if (i != n - 1) ptr = (ptr + 1) % 16;
      rbyte(i == n - 1);
    end
    chk("oe_after_nack", int'(sda_oe), 0);
    stop_c;
    chk("busy_after_read", int'(busy), 0);
  endtask

  task automatic tapchk(input int i);
    tap_addr = 4'(i);
    #1;
    chk("tap", int'(tap_data), mem[i]);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int r, n;
    logic [6:0] a;
    for (int i = 0; i < 16; i++) mem[i] = 0;
    #23;
    chk("rst_sda_oe", int'(sda_oe), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_wr_stb", int'(wr_stb), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_tap", int'(tap_data), 0);
    reset_n = 1'b1;
    wclk(10);

    wdat[0] = 'h05; wdat[1] = 'hA5; wdat[2] = 'h3C;
    t_write(7'h39, 3);
    tapchk(5);
    tapchk(6);
    t_read(1, 'h05, 2);
    wdat[0] = 'h0F; wdat[1] = 'h11; wdat[2] = 'h22;
    t_write(7'h39, 3);
    tapchk(15);
    tapchk(0);
    wdat[0] = 'h01; wdat[1] = 'hFF;
    t_write(7'h38, 2);

    // SCL glitch inside a data byte.
    glitch_at = wbit_cnt + 20;
    wdat[0] = 'h09; wdat[1] = 'h5A; wdat[2] = 'hC3;
    t_write(7'h39, 3);
    tapchk(9);
    tapchk(10);

    // STOP after four data bits: no write.
    start_c;
    wbyte({7'h39, 1'b0}, 0);
    ptr = 3;
    wbyte(8'h03, 0);
    for (int i = 0; i < 4; i++) wbit(1'($urandom_range(0, 1)));
    stop_c;
    chk("busy_after_abort", int'(busy), 0);
    t_read(0, 0, 1);

    for (int k = 0; k < 20; k++) begin
      r = $urandom_range(0, 9);
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) wdat[i] = $urandom_range(0, 255);
      if (r <= 4) t_write(7'h39, n);
      else if (r <= 7) t_read(1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom_range(1, 3));
      else if (r == 8) begin
        a = 7'($urandom_range(0, 127));
        if (a == 7'h39) a = 7'h3A;
        t_write(a, n);
      end else begin
        glitch_at = wbit_cnt + $urandom_range(1, 8 + 8 * n);
        t_write(7'h39, n);
      end
    end
    for (int i = 0; i < 16; i++) tapchk(i);

    // Reset while the address ACK is driven.
    start_c;
    for (int i = 7; i >= 0; i--) wbit(i == 0 ? 1'b0 : 1'(8'h72 >> i));
    wclk(Q); sda_m = 1'b1; wclk(Q); scl_m = 1'b1; wclk(3);
    chk("ack_driven_before_reset", int'(sda_oe), 1);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("reset_async_release", int'(sda_oe), 0);
    scl_m = 1'b1; sda_m = 1'b1;
    #40;
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 0;
    ptr = 0;
    wclk(10);
    chk("busy_after_reset", int'(busy), 0);
    for (int i = 0; i < 16; i++) tapchk(i);
    t_read(0, 0, 2);

    wclk(50);
    chk("wr_queue_drained", exp_wr_q.size(), 0);
    chk("ack_queue_drained", exp_ack_q.size(), 0);
    chk("rd_queue_drained", exp_rd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_cfg_target.md
Name: i2c_cfg_target

Overview:
- I2C target (responder) holding a small byte-wide register file. It is the other end of the I2C configuration master that drives the FMC-DVI/DP board.
- Used in simulation and on-board loopback as a stand-in for the DVI/DP transceiver, so config sequences can be checked without silicon.
- Also exposes fabric-side register taps and write strobes, so video-path logic (window, filter) can take settings over I2C.

Parameters:
- I2C_ADDR, 7'h39, 7-bit target address this block responds to.
- NUM_REGS, 16, number of 8-bit registers; power of 2, range 2..256.
- FILTER_LEN, 3, number of consecutive equal samples needed before a synced SCL/SDA level is accepted.

Ports:
- clk  in  1  system clock; at least 20x the SCL rate (50 MHz in the design).
- reset_n  in  1  asynchronous, active-low reset.
- scl_in  in  1  SCL pad input (asynchronous).
- sda_in  in  1  SDA pad input (asynchronous; from IOBUF O).
- sda_oe  out  1  1 = pull SDA low (drives IOBUF T through an inverter, I tied to 0).
- tap_addr  in  log2(NUM_REGS)  fabric read address.
- tap_data  out  8  register[tap_addr]; combinational read.
- wr_stb  out  1  one-cycle pulse when an I2C write updates a register.
- wr_addr  out  log2(NUM_REGS)  register index written; valid while wr_stb is high.
- wr_data  out  8  byte written; valid while wr_stb is high.
- busy  out  1  high from an addressed START until STOP or NACK-release.

Behaviour:
- Reset values:
  - All registers 8'h00.
  - sda_oe=0, wr_stb=0, wr_addr=0, wr_data=0, busy=0.
  - Pointer=0, state IDLE.
  - Reset mid-transfer releases SDA immediately, because the reset is asynchronous.
- Input conditioning:
  - 2-flop synchroniser on each input, then the FILTER_LEN glitch filter.
  - Edge and START/STOP detection run on filtered levels only.
  - Input-to-decision latency is 2+FILTER_LEN clk.
- Bus conditions:
  - START (or repeated START): SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Both are detected in every state and take priority over bit handling in the same cycle.
- Bit sampling:
  - Input bits are sampled on the filtered SCL rising edge, MSB first.
  - sda_oe changes only in the clk cycle after a filtered SCL falling edge. It never changes while SCL is high, except for release on STOP or reset.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7-bit address + R/W).
    - If the address equals I2C_ADDR: go to ADDR_ACK and drive ACK.
    - Else go to WAIT_STOP with SDA released.
    - General call (7'h00) is ignored.
  - ADDR_ACK: hold SDA low for the 9th clock.
    - On the falling edge after it: R/W=0 goes to PTR; R/W=1 loads the shift register from register[pointer] and goes to RDATA.
  - PTR: first written byte. Its low log2(NUM_REGS) bits load the pointer; upper bits are ignored. ACK, then go to WDATA.
  - WDATA: each byte is ACKed.
    - On the 8th SCL rising edge: write register[pointer], pulse wr_stb for 1 clk with wr_addr/wr_data, then increment the pointer.
    - The pointer wraps from NUM_REGS-1 to 0.
  - RDATA: drive bits from the shift register (sda_oe = ~bit). Release SDA for the 9th clock and sample master ACK on its rising edge.
    - ACK (0): increment the pointer with wrap, load the next byte, stay in RDATA.
    - NACK (1): go to WAIT_STOP.
  - WAIT_STOP: SDA released; wait for STOP (to IDLE) or START (to ADDR).
- Pointer persistence:
  - The pointer persists across transactions and across repeated START. Write-pointer-then-read is a random read.
  - The pointer is cleared only by reset.
- STOP or START mid-byte: abandon the partial byte with no register write, release SDA, clear busy (STOP) or re-enter ADDR (START).
- busy:
  - Set in the cycle ADDR_ACK is entered.
  - Cleared on STOP, or on entering WAIT_STOP after a NACK or address mismatch.
- Simultaneous events: a tap read of a register being written in the same clk returns the old value; the new value is visible the next clk.

Test Plan:
- Write, addr 0x72 (0x39 W), bytes 0x05, 0xA5, 0x3C, STOP -> three ACKs from target; wr_stb pulses at idx 5 data 0xA5, then idx 6 data 0x3C; tap_addr=5 reads 0xA5; busy low after STOP.
- Random read: write pointer 0x05, repeated START, addr 0x73, read 2 bytes with ACK then NACK -> SDA returns 0xA5 then 0x3C; SDA released after NACK; no wr_stb.
- Wrap: pointer 0x0F, write 0x11, 0x22 -> reg15=0x11, reg0=0x22; wr_addr sequence 15, 0.
- Address mismatch: 0x70 W, 0x01, 0xFF -> sda_oe stays 0 throughout, no wr_stb, busy stays 0.
- Robustness:
  - 1-clk glitch on SCL while high, with FILTER_LEN=3 -> ignored, no extra bit.
  - STOP after 4 bits of a data byte -> no write, state IDLE.
- Reset: assert reset_n low while ACK is driven -> sda_oe=0 asynchronously; all registers read 0x00 after release.
